// File: rtl/button_debounce_re_if.sv
// Button debouncer port bundle: raw button in, debounced level and press pulse out.
interface button_debounce_re_if;
  logic button_in;
  logic button_level;
  logic change_position_re;

  modport master (
    output button_in,
    input  button_level,
    input  change_position_re
  );

  modport slave (
    input  button_in,
    output button_level,
    output change_position_re
  );
endinterface

// File: rtl/button_debounce_re.sv
// Push-button synchroniser, debouncer and press-edge pulse generator.
// Optional auto-repeat: define BUTTON_DEBOUNCE_AUTOREPEAT_EN.
module button_debounce_re #(
  parameter int SYNC_STAGES          = 2,
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 12500000
) (
  input  logic                clk,
  input  logic                sync_reset,
  button_debounce_re_if.slave bus
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_cfg
    $error("button_debounce_re: illegal parameter value");
  end

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  localparam int MAXR = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int MAXC = (MAXR > DEBOUNCE_CYCLES) ? MAXR : DEBOUNCE_CYCLES;
`else
  localparam int MAXC = DEBOUNCE_CYCLES;
`endif
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   fire_d;
  logic                   pulse_q, pulse_d;
  logic                   level_q, re_q;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.button_in};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_PENDING;
          cnt_d   = '0;
        end
      end
      PRESS_PENDING: begin
        if (!s) begin
          state_d = RELEASED;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          fire_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_PENDING;
          cnt_d   = '0;
        end
      end
      RELEASE_PENDING: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
  // rcnt runs only while held in PRESSED; frozen across release bounces
  logic [CW-1:0] rcnt_q, rcnt_d, rcnt_inc, rtgt;
  logic          rph_q, rph_d, rep_fire;

  assign rcnt_inc = (&rcnt_q) ? rcnt_q : rcnt_q + 1'b1;
  assign rtgt     = rph_q ? CW'(REPEAT_PERIOD_CYCLES) :
                            CW'(REPEAT_DELAY_CYCLES);

  always_comb begin
    rcnt_d   = rcnt_q;
    rph_d    = rph_q;
    rep_fire = 1'b0;
    if (state_q == RELEASED || state_q == PRESS_PENDING) begin
      rcnt_d = '0;
      rph_d  = 1'b0;
    end else if (state_q == PRESSED && s) begin
      if (rcnt_inc == rtgt) begin
        rep_fire = 1'b1;
        rcnt_d   = '0;
        rph_d    = 1'b1;
      end else begin
        rcnt_d = rcnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rcnt_q <= '0;
      rph_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rph_q  <= rph_d;
    end
  end

  assign pulse_d = fire_d | rep_fire;
`else
  assign pulse_d = fire_d;
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= (state_q == PRESSED) ||
                 (state_q == RELEASE_PENDING);
      re_q    <= pulse_q;
    end
  end

  assign bus.button_level       = level_q;
  assign bus.change_position_re = re_q;

endmodule

// File: tb/tb_button_debounce_re.sv
// Directed bench for button_debounce_re (DEBOUNCE_CYCLES=4 and =1 instances).
// Expected pulse edges follow BUTTON_DEBOUNCE_AUTOREPEAT_EN when defined.
module tb_button_debounce_re;

  logic clk = 1'b0;
  logic sync_reset;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  button_debounce_re_if bus ();
  button_debounce_re_if bus1 ();

  assign bus1.button_in = bus.button_in;

  button_debounce_re #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_PERIOD_CYCLES(3)
  ) u_dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .bus(bus)
  );

  button_debounce_re #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(1),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_PERIOD_CYCLES(3)
  ) u_dut1 (
    .clk(clk),
    .sync_reset(sync_reset),
    .bus(bus1)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m(input int e);
    m = 64'd1 << e;
  endfunction

  task automatic do_reset();
    sync_reset    = 1'b1;
    bus.button_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sync_reset = 1'b0;
  endtask

  // bit k of pat is the button level sampled on edge k
  task automatic run(input string nm, input logic [63:0] pat, input int n,
                     input logic [63:0] pm, input int lon, input int loff,
                     input int rst_e, input bit c1,
                     input logic [63:0] pm1, input int lon1);
    for (int k = 0; k < n; k++) begin
      bus.button_in = pat[k];
      sync_reset    = (k == rst_e);
      @(posedge clk);
      #1;
      chk($sformatf("%s re @%0d", nm, k),
          bus.change_position_re, pm[k]);
      chk($sformatf("%s lvl @%0d", nm, k),
          bus.button_level, (k >= lon) && (k < loff));
      if (c1) begin
        chk($sformatf("%s d1 re @%0d", nm, k),
            bus1.change_position_re, pm1[k]);
        chk($sformatf("%s d1 lvl @%0d", nm, k),
            bus1.button_level, k >= lon1);
      end
    end
    sync_reset = 1'b0;
  endtask

  logic [63:0] p2, p2d1, p3, p4, p5;

  initial begin
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    p2   = m(7) | m(17) | m(20) | m(23) | m(26) | m(29);
    p2d1 = m(4) | m(14) | m(17) | m(20) | m(23) | m(26) | m(29);
    p3   = m(15) | m(25) | m(28);
    p4   = m(7) | m(17) | m(20) | m(26);
    p5   = m(13) | m(23);
`else
    p2   = m(7);
    p2d1 = m(4);
    p3   = m(15);
    p4   = m(7);
    p5   = m(13);
`endif
    do_reset();
    chk("reset re", bus.change_position_re, 1'b0);
    chk("reset lvl", bus.button_level, 1'b0);
    chk("reset d1 re", bus1.change_position_re, 1'b0);
    chk("reset d1 lvl", bus1.button_level, 1'b0);
    run("idle", 64'h0, 20, 64'h0, 99, 99, -1, 1'b1, 64'h0, 99);

    do_reset();
    run("clean", 64'h3FFF_FFFF, 30, p2, 7, 99, -1, 1'b1, p2d1, 4);

    do_reset();
    run("bounce", 64'h3FFF_FF33, 30, p3, 15, 99, -1, 1'b0, 64'h0, 0);

    do_reset();
    run("release", 64'h00CF_FFFF, 40, p4, 7, 31, -1, 1'b0, 64'h0, 0);

    do_reset();
    run("rstmid", 64'h01FF_FFFF, 25, p5, 13, 99, 5, 1'b0, 64'h0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
